// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable sequencing, frame-boundary config apply, show-ahead RX FIFO, error stats, irq.
// Optional macro UART_RX_CTRL_PERR_DROP_EN: parity-error frames are counted but never written to the FIFO.
module uart_rx_ctrl #(
  parameter int unsigned MAX_DATA_WIDTH = 8,
  parameter int unsigned CONF_WIDTH     = 5,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PERR_CNT_WIDTH = 8,
  parameter int unsigned STOP_TIMEOUT   = 255,
  parameter int unsigned IRQ_THRESHOLD  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          cfg_wr_i,
  input  logic [CONF_WIDTH-1:0]         cfg_data_i,
  input  logic                          rx_done_i,
  input  logic                          parity_error_i,
  input  logic [MAX_DATA_WIDTH-1:0]     rx_data_i,
  output logic                          rx_en_o,
  output logic [CONF_WIDTH-1:0]         rx_conf_o,
  input  logic                          rd_en_i,
  output logic [MAX_DATA_WIDTH-1:0]     rd_data_o,
  output logic                          rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overrun_o,
  output logic [PERR_CNT_WIDTH-1:0]     perr_count_o,
  input  logic                          clear_i,
  output logic                          irq_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TO_W  = (STOP_TIMEOUT > 1) ? $clog2(STOP_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_STOPPING} state_e;

  state_e                       state_q, state_d;
  logic                         rx_done_q, rx_done_d;
  logic                         rx_en_q, rx_en_d;
  logic [CONF_WIDTH-1:0]        rx_conf_q, rx_conf_d;
  logic [CONF_WIDTH-1:0]        pend_q, pend_d;
  logic [TO_W-1:0]              tmo_q, tmo_d;
  logic [MAX_DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [MAX_DATA_WIDTH-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]             level_q, level_d;
  logic [MAX_DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                         rd_valid_q, rd_valid_d;
  logic                         overrun_q, overrun_d;
  logic [PERR_CNT_WIDTH-1:0]    perr_q, perr_d;
  logic                         irq_q, irq_d;

  logic active, frame_evt, perr_evt, push_req, push, pop, full, ovf_evt;

  always_comb begin
    state_d    = state_q;
    rx_done_d  = rx_done_i;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
    rx_conf_d  = rx_conf_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overrun_d  = overrun_q;
    perr_d     = perr_q;

    active    = (state_q != ST_OFF);
    frame_evt = rx_done_i & ~rx_done_q & active;
    perr_evt  = frame_evt & parity_error_i;

    // Enable sequencing: a stop request waits for a frame boundary or the timeout
    case (state_q)
      ST_OFF: if (enable_i) state_d = ST_RUN;
      ST_RUN: begin
        if (!enable_i) begin
          state_d = ST_STOPPING;
          tmo_d   = TO_W'(STOP_TIMEOUT);
        end
      end
      ST_STOPPING: begin
        if (enable_i) begin
          state_d = ST_RUN;
        end else if (frame_evt || (tmo_q <= TO_W'(1))) begin
          state_d = ST_OFF;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q - TO_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
    rx_en_d = (state_d != ST_OFF);

    if (cfg_wr_i) pend_d = cfg_data_i;
    if (!active)        rx_conf_d = pend_q;
    else if (frame_evt) rx_conf_d = cfg_wr_i ? cfg_data_i : pend_q;

`ifdef UART_RX_CTRL_PERR_DROP_EN
    push_req = frame_evt & ~parity_error_i;
`else
    push_req = frame_evt;
`endif
    full    = (level_q == LVL_W'(FIFO_DEPTH));
    pop     = rd_en_i & rd_valid_q;
    push    = push_req & (~full | pop);
    ovf_evt = push_req & full & ~pop;

    if (push) begin
      mem_d[wr_ptr_q] = rx_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    rd_valid_d = (level_d != '0);
    // Head lookup uses the post-write image so a push into an empty FIFO shows immediately
    rd_data_d  = mem_d[rd_ptr_d];

    if (clear_i) begin
      overrun_d = ovf_evt;
      perr_d    = perr_evt ? PERR_CNT_WIDTH'(1) : '0;
    end else begin
      overrun_d = overrun_q | ovf_evt;
      if (perr_evt && (perr_q != '1)) perr_d = perr_q + PERR_CNT_WIDTH'(1);
    end

    irq_d = (level_q >= LVL_W'(IRQ_THRESHOLD)) | overrun_q | (perr_q != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_OFF;
      rx_done_q  <= 1'b0;
      rx_en_q    <= 1'b0;
      rx_conf_q  <= '0;
      pend_q     <= '0;
      tmo_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      perr_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_done_q  <= rx_done_d;
      rx_en_q    <= rx_en_d;
      rx_conf_q  <= rx_conf_d;
      pend_q     <= pend_d;
      tmo_q      <= tmo_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
      perr_q     <= perr_d;
      irq_q      <= irq_d;
    end
  end

  assign rx_en_o      = rx_en_q;
  assign rx_conf_o    = rx_conf_q;
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign fifo_level_o = level_q;
  assign overrun_o    = overrun_q;
  assign perr_count_o = perr_q;
  assign irq_o        = irq_q;

endmodule
